// File: rtl/qq_pkg.sv
// Shared types and constants for the qq_op_ctrl sorted-queue controller.
package qq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENQ_SCAN  = 2'd1,
        DEQ_SHIFT = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam logic OP_ENQ = 1'b0;
    localparam logic OP_DEQ = 1'b1;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_KW    = 32;

endpackage

// File: rtl/qq_op_ctrl_if.sv
// Command handshake and dequeue-result bundle between a requester and qq_op_ctrl.
interface qq_op_ctrl_if
    import qq_pkg::*;
#(
    parameter int KW = DEFAULT_KW
);
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [KW-1:0] in_key;
    logic          deq_valid;
    logic [KW-1:0] deq_key;

    modport master (
        output in_valid, in_op, in_key,
        input  in_ready, deq_valid, deq_key
    );

    modport slave (
        input  in_valid, in_op, in_key,
        output in_ready, deq_valid, deq_key
    );
endinterface

// File: rtl/qq_stats.sv
// Wrapping 32-bit event counters for completed enqueues, dequeues and rejects.
module qq_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_i,
    input  logic        deq_i,
    input  logic        err_i,
    output logic [31:0] stat_enq_o,
    output logic [31:0] stat_deq_o,
    output logic [31:0] stat_err_o
);
    logic [31:0] statEnq_q;
    logic [31:0] statDeq_q;
    logic [31:0] statErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statEnq_q <= '0;
            statDeq_q <= '0;
            statErr_q <= '0;
        end else begin
            if (enq_i) statEnq_q <= statEnq_q + 32'd1;
            if (deq_i) statDeq_q <= statDeq_q + 32'd1;
            if (err_i) statErr_q <= statErr_q + 32'd1;
        end
    end

    assign stat_enq_o = statEnq_q;
    assign stat_deq_o = statDeq_q;
    assign stat_err_o = statErr_q;
endmodule

// File: rtl/qq_op_ctrl.sv
// Sorted key queue (smallest-first) built from an insertion-scan / shift-down register array.
// Optional statistics counters are enabled with the QQ_STATS_EN macro.
module qq_op_ctrl
    import qq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int KW    = DEFAULT_KW
) (
    input  logic        clk,
    input  logic        rst,
    qq_op_ctrl_if.slave bus,
    output logic        enq,
    output logic        deq,
    output logic        done,
    output logic        err,
    output logic [31:0] last_addr,
    output logic        full,
    output logic        empty,
    output logic [31:0] stat_enq,
    output logic [31:0] stat_deq,
    output logic [31:0] stat_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] idx_q;
    logic [KW-1:0] keys_q [DEPTH];
    logic [KW-1:0] keyLatch_q;
    logic [KW-1:0] deqKey_q;
    logic          enq_q;
    logic          deq_q;
    logic          err_q;

    logic [AW-1:0] idxPrev;
    logic [AW-1:0] idxNext;
    logic          isFull;
    logic          isEmpty;

    assign idxPrev = idx_q - AW'(1);
    assign idxNext = idx_q + AW'(1);
    assign isFull  = (count_q == CW'(DEPTH));
    assign isEmpty = (count_q == '0);

    // keyLatch_q holds the new key while scanning, or the removed head while shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            keyLatch_q <= '0;
            deqKey_q   <= '0;
            enq_q      <= 1'b0;
            deq_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) keys_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_op == OP_ENQ) begin
                            if (isFull) begin
                                err_q   <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                keyLatch_q <= bus.in_key;
                                idx_q      <= count_q[AW-1:0];
                                state_q    <= ENQ_SCAN;
                            end
                        end else if (isEmpty) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (count_q > CW'(1)) begin
                            keyLatch_q <= keys_q[0];
                            idx_q      <= '0;
                            state_q    <= DEQ_SHIFT;
                        end else begin
                            deqKey_q <= keys_q[0];
                            deq_q    <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                ENQ_SCAN: begin
                    // Strict compare keeps equal keys in arrival order.
                    if (idx_q != '0 && keys_q[idxPrev] > keyLatch_q) begin
                        keys_q[idx_q] <= keys_q[idxPrev];
                        idx_q         <= idxPrev;
                    end else begin
                        keys_q[idx_q] <= keyLatch_q;
                        enq_q         <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DEQ_SHIFT: begin
                    keys_q[idx_q] <= keys_q[idxNext];
                    if (CW'(idx_q) == count_q - CW'(2)) begin
                        deqKey_q <= keyLatch_q;
                        deq_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idxNext;
                    end
                end
                DONE: begin
                    if (enq_q) count_q <= count_q + CW'(1);
                    if (deq_q) count_q <= count_q - CW'(1);
                    enq_q   <= 1'b0;
                    deq_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign done          = (state_q == DONE) && !rst;
    assign enq           = enq_q && !rst;
    assign deq           = deq_q && !rst;
    assign err           = err_q && !rst;
    assign bus.deq_valid = deq;
    assign bus.deq_key   = deqKey_q;
    assign last_addr     = rst ? 32'd0 : 32'(count_q);
    assign full          = isFull && !rst;
    assign empty         = isEmpty || rst;

`ifdef QQ_STATS_EN
    qq_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .enq_i      (enq),
        .deq_i      (deq),
        .err_i      (err),
        .stat_enq_o (stat_enq),
        .stat_deq_o (stat_deq),
        .stat_err_o (stat_err)
    );
`else
    assign stat_enq = 32'd0;
    assign stat_deq = 32'd0;
    assign stat_err = 32'd0;
`endif
endmodule

// File: tb/tb_qq_op_ctrl.sv
// Directed self-checking bench for qq_op_ctrl (DEPTH=16, KW=32); expects zero stats unless QQ_STATS_EN.
module tb_qq_op_ctrl;
    import qq_pkg::*;

    localparam int DEPTH = 16;
    localparam int KW    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq, deq, done, err, full, empty;
    logic [31:0] last_addr, stat_enq, stat_deq, stat_err;

    int checkCount = 0;
    int errorCount = 0;

    qq_op_ctrl_if #(.KW(KW)) bus ();

    qq_op_ctrl #(.DEPTH(DEPTH), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enq       (enq),
        .deq       (deq),
        .done      (done),
        .err       (err),
        .last_addr (last_addr),
        .full      (full),
        .empty     (empty),
        .stat_enq  (stat_enq),
        .stat_deq  (stat_deq),
        .stat_err  (stat_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one command and returns at the negedge where done is seen; cycles counts negedges after accept.
    task automatic applyStimulus(input logic op, input logic [KW-1:0] key, output int cycles);
        int waitCount = 0;
        while (!bus.in_ready && waitCount < 50) begin
            @(negedge clk);
            waitCount++;
        end
        if (!bus.in_ready) checkOutput("ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_key   = key;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op    = ~op;
        bus.in_key   = $urandom();
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 100);
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic pushKey(input logic [KW-1:0] key);
        int c;
        applyStimulus(OP_ENQ, key, c);
        checkOutput("push_enq", enq, 1);
        @(negedge clk);
    endtask

    task automatic popKey(input logic [KW-1:0] expKey);
        int c;
        applyStimulus(OP_DEQ, '0, c);
        checkOutput("pop_key", bus.deq_key, expKey);
        checkOutput("pop_valid", bus.deq_valid, 1);
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        logic [KW-1:0] keysA [4];
        logic [KW-1:0] popA  [4];
        int            enqLat[4];
        int            deqLat[4];
        logic          sawDone;

        keysA  = '{32'd5, 32'd3, 32'd9, 32'd3};
        popA   = '{32'd3, 32'd3, 32'd5, 32'd9};
        enqLat = '{2, 3, 2, 4};
        deqLat = '{4, 3, 2, 1};

        bus.in_valid = 1'b0;
        bus.in_op    = OP_ENQ;
        bus.in_key   = '0;
        rst          = 1'b1;

        // Reset state observed while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_deq_valid", bus.deq_valid, 0);
        checkOutput("rst_last_addr", last_addr, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_deq_key", bus.deq_key, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", bus.in_ready, 1);

        // Dequeue from empty queue is rejected
        applyStimulus(OP_DEQ, '0, c);
        checkOutput("empty_deq_lat", c, 1);
        checkOutput("empty_deq_err", err, 1);
        checkOutput("empty_deq_deq", deq, 0);
        checkOutput("empty_deq_enq", enq, 0);
        checkOutput("empty_deq_valid", bus.deq_valid, 0);
        checkOutput("empty_deq_addr", last_addr, 0);
        @(negedge clk);
        checkOutput("empty_deq_after", last_addr, 0);

        // Enqueue 5,3,9,3 then drain in sorted order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_ENQ, keysA[i], c);
            checkOutput("seqA_enq_lat", c, enqLat[i]);
            checkOutput("seqA_enq_flag", enq, 1);
            checkOutput("seqA_addr_hold", last_addr, i);
            @(negedge clk);
            checkOutput("seqA_enq_addr", last_addr, i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_DEQ, '0, c);
            checkOutput("seqA_deq_lat", c, deqLat[i]);
            checkOutput("seqA_deq_key", bus.deq_key, popA[i]);
            checkOutput("seqA_deq_flag", deq, 1);
            checkOutput("seqA_deq_valid", bus.deq_valid, 1);
            @(negedge clk);
            checkOutput("seqA_deq_addr", last_addr, 3 - i);
        end
        checkOutput("deq_key_hold", bus.deq_key, 9);
        checkOutput("deq_valid_low", bus.deq_valid, 0);
        checkOutput("seqA_empty", empty, 1);

        // Insert 1 at the head of {2,4,6,8}
        pushKey(2); pushKey(4); pushKey(6); pushKey(8);
        applyStimulus(OP_ENQ, 32'd1, c);
        checkOutput("head_ins_lat", c, 6);
        checkOutput("head_ins_addr_hold", last_addr, 4);
        @(negedge clk);
        checkOutput("head_ins_addr", last_addr, 5);
        popKey(1); popKey(2); popKey(4); popKey(6); popKey(8);

        // Fill to DEPTH, reject an extra enqueue, then dequeue once
        for (int k = 0; k < DEPTH; k++) pushKey(KW'(100 + k));
        checkOutput("fill_full", full, 1);
        checkOutput("fill_addr", last_addr, DEPTH);
        applyStimulus(OP_ENQ, 32'd7, c);
        checkOutput("full_enq_err", err, 1);
        checkOutput("full_enq_enq", enq, 0);
        @(negedge clk);
        checkOutput("full_enq_full", full, 1);
        checkOutput("full_enq_addr", last_addr, DEPTH);
        applyStimulus(OP_DEQ, '0, c);
        checkOutput("full_deq_lat", c, DEPTH);
        checkOutput("full_deq_key", bus.deq_key, 100);
        @(negedge clk);
        checkOutput("full_deq_full", full, 0);
        checkOutput("full_deq_addr", last_addr, DEPTH - 1);
        for (int k = 1; k < 8; k++) popKey(KW'(100 + k));
        checkOutput("pre_abort_addr", last_addr, 8);

        // Reset while shifting a dequeue out of an 8-entry queue
        bus.in_valid = 1'b1;
        bus.in_op    = OP_DEQ;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sawDone = done;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sawDone = sawDone | done;
        end
        checkOutput("abort_rst_addr", last_addr, 0);
        checkOutput("abort_rst_empty", empty, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) checkOutput("abort_ready", bus.in_ready, 0);
            @(negedge clk);
            if (k == 0) checkOutput("abort_ready_rel", bus.in_ready, 1);
            sawDone = sawDone | done;
        end
        checkOutput("abort_no_done", sawDone, 0);
        checkOutput("abort_addr", last_addr, 0);
        checkOutput("abort_empty", empty, 1);
        checkOutput("abort_deq_key", bus.deq_key, 0);

        // Statistics: one reject, three enqueues, one dequeue
        applyReset();
        checkOutput("stat_rst_enq", stat_enq, 0);
        applyStimulus(OP_DEQ, '0, c);
        checkOutput("stat_rej_err", err, 1);
        @(negedge clk);
        pushKey(30); pushKey(10); pushKey(20);
        popKey(10);
        checkOutput("stat_addr", last_addr, 2);
`ifdef QQ_STATS_EN
        checkOutput("stat_enq", stat_enq, 3);
        checkOutput("stat_deq", stat_deq, 1);
        checkOutput("stat_err", stat_err, 1);
`else
        checkOutput("stat_enq", stat_enq, 0);
        checkOutput("stat_deq", stat_deq, 0);
        checkOutput("stat_err", stat_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
